// File: rtl/pc_sequencer_pkg.sv
// Shared types and default parameters for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int D_DEF         = 12;
    localparam int OFFW_DEF      = 8;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        BRZ  = 3'd1,
        BRNZ = 3'd2,
        JREL = 3'd3,
        JMP  = 3'd4,
        CALL = 3'd5,
        RET  = 3'd6,
        HALT = 3'd7
    } br_op_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } seq_state_t;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address LIFO; push when full and pop when empty are silently dropped.
module ret_addr_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_top,
    output logic [$clog2(DEPTH):0]   o_depth,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW:0]   r_depth;
    logic [AW-1:0] w_top_idx;

    assign w_top_idx = AW'(r_depth - 1'b1);
    assign o_top     = r_mem[w_top_idx];
    assign o_depth   = r_depth;
    assign o_full    = (r_depth == (AW+1)'(DEPTH));
    assign o_empty   = (r_depth == '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_depth <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_push && !o_full) begin
            r_mem[r_depth[AW-1:0]] <= i_data;
            r_depth                <= r_depth + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_depth <= r_depth - 1'b1;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Branch-op decoder and start/halt/stall sequencer driving the PC jump controls.
// Optional PC_SEQUENCER_PERF_EN adds saturating RUN-cycle and taken-jump counters.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int D         = D_DEF,
    parameter int OFFW      = OFFW_DEF,
    parameter int RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    input  logic                        i_start,
    input  logic                        i_stall,
    input  br_op_t                      i_br_op,
    input  logic                        i_zero_flag,
    input  logic [OFFW-1:0]             i_offset,
    input  logic [D-1:0]                i_abs_addr,
    input  logic [D-1:0]                i_prog_ctr,
    output logic                        o_reljump_en,
    output logic                        o_absjump_en,
    output logic [D-1:0]                o_target,
    output logic                        o_halted,
    output logic [$clog2(RAS_DEPTH):0]  o_ras_depth,
    output logic                        o_err_ovf,
    output logic                        o_err_unf
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [31:0]                 o_cyc_cnt,
    output logic [31:0]                 o_taken_cnt
`endif
);
    seq_state_t r_state, w_nstate;
    logic       r_halted, r_err_ovf, r_err_unf;

    logic         w_rel, w_abs, w_push, w_pop;
    logic         w_set_ovf, w_set_unf, w_set_halt, w_taken;
    logic [D-1:0] w_tgt, w_ofs_ext, w_ret_addr, w_top;
    logic         w_full, w_empty;

    assign w_ofs_ext  = D'($signed(i_offset));
    assign w_ret_addr = i_prog_ctr + D'(1);

    ret_addr_stack #(.W(D), .DEPTH(RAS_DEPTH)) u_ras (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_depth (o_ras_depth),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_rel      = 1'b0;
        w_abs      = 1'b0;
        w_tgt      = '0;
        w_push     = 1'b0;
        w_pop      = 1'b0;
        w_set_ovf  = 1'b0;
        w_set_unf  = 1'b0;
        w_set_halt = 1'b0;
        w_taken    = 1'b0;
        w_nstate   = r_state;
        case (r_state)
            IDLE: begin
                w_abs = 1'b1;
                w_tgt = i_prog_ctr;
                if (i_start) w_nstate = RUN;
            end
            RUN: begin
                if (i_stall) begin
                    w_abs = 1'b1;
                    w_tgt = i_prog_ctr;
                end else begin
                    case (i_br_op)
                        NONE: ;
                        BRZ: if (i_zero_flag) begin
                            w_rel = 1'b1;
                            w_tgt = w_ofs_ext;
                        end
                        BRNZ: if (!i_zero_flag) begin
                            w_rel = 1'b1;
                            w_tgt = w_ofs_ext;
                        end
                        JREL: begin
                            w_rel = 1'b1;
                            w_tgt = w_ofs_ext;
                        end
                        JMP: begin
                            w_abs = 1'b1;
                            w_tgt = i_abs_addr;
                        end
                        CALL: begin
                            // The jump is taken even when the return address cannot be saved.
                            w_abs     = 1'b1;
                            w_tgt     = i_abs_addr;
                            w_push    = !w_full;
                            w_set_ovf = w_full;
                        end
                        RET: begin
                            if (!w_empty) begin
                                w_abs = 1'b1;
                                w_tgt = w_top;
                                w_pop = 1'b1;
                            end else begin
                                w_set_unf = 1'b1;
                            end
                        end
                        HALT: begin
                            w_abs      = 1'b1;
                            w_tgt      = i_prog_ctr;
                            w_set_halt = 1'b1;
                            w_nstate   = HALTED;
                        end
                        default: ;
                    endcase
                    w_taken = (w_rel || w_abs) && (i_br_op != HALT);
                end
            end
            HALTED: begin
                w_abs = 1'b1;
                w_tgt = i_prog_ctr;
            end
            default: w_nstate = IDLE;
        endcase
    end

    assign o_reljump_en = w_rel;
    assign o_absjump_en = w_abs;
    assign o_target     = w_tgt;
    assign o_halted     = r_halted;
    assign o_err_ovf    = r_err_ovf;
    assign o_err_unf    = r_err_unf;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_halted  <= 1'b0;
            r_err_ovf <= 1'b0;
            r_err_unf <= 1'b0;
        end else begin
            r_state <= w_nstate;
            if (w_set_halt) r_halted  <= 1'b1;
            if (w_set_ovf)  r_err_ovf <= 1'b1;
            if (w_set_unf)  r_err_unf <= 1'b1;
        end
    end

`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] r_cyc_cnt, r_taken_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cyc_cnt   <= '0;
            r_taken_cnt <= '0;
        end else if (r_state == RUN) begin
            if (r_cyc_cnt != '1)             r_cyc_cnt   <= r_cyc_cnt + 32'd1;
            if (w_taken && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign o_cyc_cnt   = r_cyc_cnt;
    assign o_taken_cnt = r_taken_cnt;
`else
    logic w_unused;
    assign w_unused = w_taken;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer; the bench also plays the PC register.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int S_IDLE = 0, S_RUN = 1, S_HALT = 2;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stall = 1'b0;
    br_op_t      i_br_op = NONE;
    logic        i_zero_flag = 1'b0;
    logic [7:0]  i_offset = '0;
    logic [11:0] i_abs_addr = '0;
    logic [11:0] i_prog_ctr = '0;
    logic        o_reljump_en, o_absjump_en;
    logic [11:0] o_target;
    logic        o_halted, o_err_ovf, o_err_unf;
    logic [2:0]  o_ras_depth;
`ifdef PC_SEQUENCER_PERF_EN
    logic [31:0] o_cyc_cnt, o_taken_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    int          m_state;
    logic [11:0] m_pc;
    logic [11:0] m_stk[$];
    logic        m_halted, m_ovf, m_unf;

    always #5 i_clk = ~i_clk;

    pc_sequencer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_stall      (i_stall),
        .i_br_op      (i_br_op),
        .i_zero_flag  (i_zero_flag),
        .i_offset     (i_offset),
        .i_abs_addr   (i_abs_addr),
        .i_prog_ctr   (i_prog_ctr),
        .o_reljump_en (o_reljump_en),
        .o_absjump_en (o_absjump_en),
        .o_target     (o_target),
        .o_halted     (o_halted),
        .o_ras_depth  (o_ras_depth),
        .o_err_ovf    (o_err_ovf),
        .o_err_unf    (o_err_unf)
`ifdef PC_SEQUENCER_PERF_EN
        ,
        .o_cyc_cnt    (o_cyc_cnt),
        .o_taken_cnt  (o_taken_cnt)
`endif
    );

    task automatic do_reset();
        i_reset = 1'b1; i_start = 1'b0; i_stall = 1'b0; i_br_op = NONE;
        @(posedge i_clk); #1;
        i_reset  = 1'b0;
        m_state  = S_IDLE;
        m_pc     = '0;
        m_stk.delete();
        m_halted = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    endtask

    // One cycle: drive, check against the model, clock, then advance PC from DUT outputs.
    task automatic step(input logic st, input logic sl, input br_op_t op, input logic zf,
                        input logic [7:0] off, input logic [11:0] aa);
        logic        e_rel, e_abs;
        logic [11:0] e_tgt;
        int          n_state, sofs;
        logic        a_rel, a_abs;
        logic [11:0] a_tgt;
        i_start = st; i_stall = sl; i_br_op = op; i_zero_flag = zf;
        i_offset = off; i_abs_addr = aa; i_prog_ctr = m_pc;
        #1;
        total++;
        if ({o_halted, o_ras_depth, o_err_ovf, o_err_unf} !==
            {m_halted, 3'(m_stk.size()), m_ovf, m_unf}) begin
            bad++;
            $display("FAIL status: got halted=%0b depth=%0d ovf=%0b unf=%0b want %0b %0d %0b %0b",
                     o_halted, o_ras_depth, o_err_ovf, o_err_unf, m_halted, m_stk.size(), m_ovf, m_unf);
        end
        sofs = int'(off);
        if (sofs >= 128) sofs -= 256;
        e_rel = 1'b0; e_abs = 1'b0; e_tgt = '0; n_state = m_state;
        if (m_state == S_IDLE) begin
            e_abs = 1'b1; e_tgt = m_pc;
            if (st) n_state = S_RUN;
        end else if (m_state == S_HALT || sl) begin
            e_abs = 1'b1; e_tgt = m_pc;
        end else begin
            case (op)
                BRZ:  if (zf)  begin e_rel = 1'b1; e_tgt = 12'(sofs); end
                BRNZ: if (!zf) begin e_rel = 1'b1; e_tgt = 12'(sofs); end
                JREL: begin e_rel = 1'b1; e_tgt = 12'(sofs); end
                JMP:  begin e_abs = 1'b1; e_tgt = aa; end
                CALL: begin
                    e_abs = 1'b1; e_tgt = aa;
                    if (m_stk.size() < 4) m_stk.push_back(12'((int'(m_pc) + 1) % 4096));
                    else m_ovf = 1'b1;
                end
                RET: begin
                    if (m_stk.size() > 0) begin
                        e_abs = 1'b1; e_tgt = m_stk[$];
                        void'(m_stk.pop_back());
                    end else m_unf = 1'b1;
                end
                HALT: begin
                    e_abs = 1'b1; e_tgt = m_pc; n_state = S_HALT; m_halted = 1'b1;
                end
                default: ;
            endcase
        end
        total++;
        if ({o_reljump_en, o_absjump_en, o_target} !== {e_rel, e_abs, e_tgt}) begin
            bad++;
            $display("FAIL jump op=%0d pc=%h: got rel=%0b abs=%0b tgt=%h want rel=%0b abs=%0b tgt=%h",
                     op, m_pc, o_reljump_en, o_absjump_en, o_target, e_rel, e_abs, e_tgt);
        end
        total++;
        if (o_reljump_en && o_absjump_en) begin
            bad++;
            $display("FAIL both_en: got rel=1 abs=1 want at most one");
        end
        a_rel = o_reljump_en; a_abs = o_absjump_en; a_tgt = o_target;
        @(posedge i_clk); #1;
        m_state = n_state;
        if (a_abs)      m_pc = a_tgt;
        else if (a_rel) m_pc = m_pc + a_tgt;
        else            m_pc = m_pc + 12'd1;
    endtask

    task automatic expect_pc(input string nm, input logic [11:0] want);
        total++;
        if (m_pc !== want) begin
            bad++;
            $display("FAIL %s: got pc=%h want %h", nm, m_pc, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, br_op_t'(i), 1'b1, 8'h05, 12'h123);
        expect_pc("idle_pc", 12'h000);
        total++;
        if ({o_halted, o_ras_depth, o_err_ovf, o_err_unf} !== 6'b0) begin
            bad++;
            $display("FAIL reset_status: got %b want 000000",
                     {o_halted, o_ras_depth, o_err_ovf, o_err_unf});
        end
    endtask

    task automatic test_rel_branch();
        do_reset(); m_pc = 12'h010;
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b0, BRZ, 1'b1, 8'hFC, 12'h000);
        expect_pc("brz_taken", 12'h00C);
        do_reset(); m_pc = 12'h010;
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b0, BRZ, 1'b0, 8'hFC, 12'h000);
        expect_pc("brz_not_taken", 12'h011);
        m_pc = 12'hFFE;
        step(1'b0, 1'b0, JREL, 1'b0, 8'h05, 12'h000);
        expect_pc("jrel_wrap", 12'h003);
    endtask

    task automatic test_call_ret();
        do_reset(); m_pc = 12'h020;
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b0, CALL, 1'b0, 8'h00, 12'h100);
        step(1'b0, 1'b0, CALL, 1'b0, 8'h00, 12'h200);
        total++;
        if (o_ras_depth !== 3'd2) begin
            bad++; $display("FAIL nest_depth: got %0d want 2", o_ras_depth);
        end
        step(1'b0, 1'b0, RET, 1'b0, 8'h00, 12'h000);
        expect_pc("ret1", 12'h101);
        step(1'b0, 1'b0, RET, 1'b0, 8'h00, 12'h000);
        expect_pc("ret2", 12'h021);
        total++;
        if ({o_ras_depth, o_err_ovf, o_err_unf} !== 5'b0) begin
            bad++; $display("FAIL nest_end: got depth=%0d ovf=%0b unf=%0b want 0 0 0",
                            o_ras_depth, o_err_ovf, o_err_unf);
        end
        m_pc = 12'hFFF;
        step(1'b0, 1'b0, CALL, 1'b0, 8'h00, 12'h040);
        step(1'b0, 1'b0, RET, 1'b0, 8'h00, 12'h000);
        expect_pc("ret_wrap", 12'h000);
    endtask

    task automatic test_stack_limits();
        do_reset();
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, CALL, 1'b0, 8'h00, 12'(12'h400 + i * 16));
        expect_pc("ovf_jump", 12'h440);
        total++;
        if ({o_err_ovf, o_ras_depth} !== {1'b1, 3'd4}) begin
            bad++; $display("FAIL ovf: got ovf=%0b depth=%0d want 1 4", o_err_ovf, o_ras_depth);
        end
        do_reset(); m_pc = 12'h050;
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b0, RET, 1'b0, 8'h00, 12'h000);
        expect_pc("unf_inc", 12'h051);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        total++;
        if (o_err_unf !== 1'b1) begin
            bad++; $display("FAIL unf_sticky: got %0b want 1", o_err_unf);
        end
        do_reset();
        total++;
        if (o_err_unf !== 1'b0) begin
            bad++; $display("FAIL unf_clear: got %0b want 0", o_err_unf);
        end
    endtask

    task automatic test_stall_halt();
        do_reset(); m_pc = 12'h0A0;
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b1, JMP, 1'b0, 8'h00, 12'h300);
        step(1'b0, 1'b1, JMP, 1'b0, 8'h00, 12'h300);
        expect_pc("stall_hold", 12'h0A0);
        step(1'b0, 1'b0, JMP, 1'b0, 8'h00, 12'h300);
        expect_pc("jmp_taken", 12'h300);
        step(1'b0, 1'b0, HALT, 1'b0, 8'h00, 12'h000);
        total++;
        if (o_halted !== 1'b1) begin
            bad++; $display("FAIL halt: got %0b want 1", o_halted);
        end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, JMP, 1'b0, 8'h00, 12'h777);
        expect_pc("halt_frozen", 12'h300);
        do_reset();
        step(1'b0, 1'b0, JMP, 1'b0, 8'h00, 12'h777);
        expect_pc("reset_idle", 12'h000);
    endtask

    task automatic test_random();
        br_op_t op;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            op = br_op_t'($urandom_range(0, 6));
            if ($urandom_range(0, 60) == 0) op = HALT;
            if ($urandom_range(0, 120) == 0) do_reset();
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), op,
                 1'($urandom_range(0, 1)), 8'($urandom), 12'($urandom));
            if (m_state == S_HALT && $urandom_range(0, 3) == 0) do_reset();
        end
    endtask

`ifdef PC_SEQUENCER_PERF_EN
    task automatic test_perf();
        do_reset();
        step(1'b1, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b0, JMP,  1'b0, 8'h00, 12'h080);
        step(1'b0, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        step(1'b0, 1'b1, JMP,  1'b0, 8'h00, 12'h100);
        step(1'b0, 1'b0, BRZ,  1'b1, 8'h04, 12'h000);
        step(1'b0, 1'b0, BRZ,  1'b0, 8'h04, 12'h000);
        step(1'b0, 1'b0, JREL, 1'b0, 8'hF0, 12'h000);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        total++;
        if ({o_cyc_cnt, o_taken_cnt} !== {32'd10, 32'd3}) begin
            bad++; $display("FAIL perf: got cyc=%0d taken=%0d want 10 3", o_cyc_cnt, o_taken_cnt);
        end
        step(1'b0, 1'b0, HALT, 1'b0, 8'h00, 12'h000);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, NONE, 1'b0, 8'h00, 12'h000);
        total++;
        if ({o_cyc_cnt, o_taken_cnt} !== {32'd11, 32'd3}) begin
            bad++; $display("FAIL perf_halt: got cyc=%0d taken=%0d want 11 3", o_cyc_cnt, o_taken_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rel_branch();
        test_call_ret();
        test_stack_limits();
        test_stall_halt();
        test_random();
`ifdef PC_SEQUENCER_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
